// File: rtl/uram_port_arbiter.sv
// Lookup/config arbiter and read-tag sequencer for one UltraRAM port.
// Optional power-up table clear is enabled with `define URAM_ARB_INIT_EN.
module uram_port_arbiter #(
    parameter int AWIDTH     = 12,
    parameter int DWIDTH     = 72,
    parameter int NBPIPE     = 3,
    parameter int STARVE_MAX = 7
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              lk_req_valid,
    output logic              lk_req_ready,
    input  logic              lk_req_we,
    input  logic [AWIDTH-1:0] lk_req_addr,
    input  logic [DWIDTH-1:0] lk_req_wdata,
    output logic              lk_rsp_valid,
    output logic [DWIDTH-1:0] lk_rsp_data,
    input  logic              cf_req_valid,
    output logic              cf_req_ready,
    input  logic              cf_req_we,
    input  logic [AWIDTH-1:0] cf_req_addr,
    input  logic [DWIDTH-1:0] cf_req_wdata,
    output logic              cf_rsp_valid,
    output logic [DWIDTH-1:0] cf_rsp_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    output logic              ram_regce,
    output logic              ram_rst,
    input  logic [DWIDTH-1:0] ram_dout,
    output logic              init_done
);

    localparam int         DEPTH      = NBPIPE + 2;
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

`ifdef URAM_ARB_INIT_EN
    localparam state_t RESET_STATE = ST_INIT;
    logic [AWIDTH:0] init_cnt_r;
`else
    localparam state_t RESET_STATE = ST_RUN;
`endif

    state_t              state_r;
    state_t              state_nxt_s;
    logic [7:0]          starve_cnt_r;
    logic                starve_hit_s;
    logic                run_s;
    logic                lk_grant_s;
    logic                cf_grant_s;
    logic                acc_s;
    logic                sel_we_s;
    logic [AWIDTH-1:0]   sel_addr_s;
    logic [DWIDTH-1:0]   sel_wdata_s;
    logic                ram_en_r;
    logic                ram_we_r;
    logic                ram_src_r;
    logic [AWIDTH-1:0]   ram_addr_r;
    logic [DWIDTH-1:0]   ram_din_r;
    logic [DEPTH-1:0]    lk_tag_r;
    logic [DEPTH-1:0]    cf_tag_r;
    logic                init_done_r;

    // Grant decision: lookup wins unless config has waited STARVE_MAX lookup grants
    always_comb begin
        starve_hit_s = (starve_cnt_r == STARVE_LIM);
        run_s        = rstn && (state_r == ST_RUN);
        if (run_s) begin
            lk_grant_s = lk_req_valid && !(cf_req_valid && starve_hit_s);
            cf_grant_s = cf_req_valid && !(lk_req_valid && !starve_hit_s);
        end else begin
            lk_grant_s = 1'b0;
            cf_grant_s = 1'b0;
        end
        acc_s = lk_grant_s || cf_grant_s;
    end

    // Command mux of the granted requester
    always_comb begin
        sel_we_s    = lk_req_we;
        sel_addr_s  = lk_req_addr;
        sel_wdata_s = lk_req_wdata;
        if (cf_grant_s) begin
            sel_we_s    = cf_req_we;
            sel_addr_s  = cf_req_addr;
            sel_wdata_s = cf_req_wdata;
        end else begin
            sel_we_s    = lk_req_we;
            sel_addr_s  = lk_req_addr;
            sel_wdata_s = lk_req_wdata;
        end
    end

    // Next-state logic: INIT leaves once the sweep counter has passed the last address
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
`ifdef URAM_ARB_INIT_EN
                if (init_cnt_r[AWIDTH]) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
`else
                state_nxt_s = ST_RUN;
`endif
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = RESET_STATE;
        endcase
    end

    // State register and init_done flag
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= RESET_STATE;
            init_done_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_nxt_s == ST_RUN) begin
                init_done_r <= 1'b1;
            end else begin
                init_done_r <= init_done_r;
            end
        end
    end

`ifdef URAM_ARB_INIT_EN
    // Clear-sweep address counter; the extra top bit marks sweep completion
    always_ff @(posedge clk) begin
        if (!rstn) begin
            init_cnt_r <= '0;
        end else if (state_r == ST_INIT && !init_cnt_r[AWIDTH]) begin
            init_cnt_r <= init_cnt_r + {{AWIDTH{1'b0}}, 1'b1};
        end else begin
            init_cnt_r <= init_cnt_r;
        end
    end
`endif

    // Starvation counter for the config requester
    always_ff @(posedge clk) begin
        if (!rstn) begin
            starve_cnt_r <= 8'd0;
        end else if (!cf_req_valid || cf_grant_s) begin
            starve_cnt_r <= 8'd0;
        end else if (lk_grant_s && !starve_hit_s) begin
            starve_cnt_r <= starve_cnt_r + 8'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Registered RAM command; address/data hold when idle
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ram_en_r   <= 1'b0;
            ram_we_r   <= 1'b0;
            ram_src_r  <= 1'b0;
            ram_addr_r <= '0;
            ram_din_r  <= '0;
        end else if (acc_s) begin
            ram_en_r   <= 1'b1;
            ram_we_r   <= sel_we_s;
            ram_src_r  <= cf_grant_s;
            ram_addr_r <= sel_addr_s;
            ram_din_r  <= sel_wdata_s;
`ifdef URAM_ARB_INIT_EN
        end else if (state_r == ST_INIT && !init_cnt_r[AWIDTH]) begin
            ram_en_r   <= 1'b1;
            ram_we_r   <= 1'b1;
            ram_src_r  <= 1'b0;
            ram_addr_r <= init_cnt_r[AWIDTH-1:0];
            ram_din_r  <= '0;
`endif
        end else begin
            ram_en_r   <= 1'b0;
            ram_we_r   <= 1'b0;
            ram_src_r  <= 1'b0;
            ram_addr_r <= ram_addr_r;
            ram_din_r  <= ram_din_r;
        end
    end

    // Read tags ride alongside the RAM pipeline; one shift register per requester
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lk_tag_r <= '0;
            cf_tag_r <= '0;
        end else begin
            lk_tag_r <= {lk_tag_r[DEPTH-2:0], ram_en_r & ~ram_we_r & ~ram_src_r};
            cf_tag_r <= {cf_tag_r[DEPTH-2:0], ram_en_r & ~ram_we_r &  ram_src_r};
        end
    end

    assign lk_req_ready = lk_grant_s;
    assign cf_req_ready = cf_grant_s;
    assign lk_rsp_valid = lk_tag_r[DEPTH-1];
    assign cf_rsp_valid = cf_tag_r[DEPTH-1];
    assign lk_rsp_data  = ram_dout;
    assign cf_rsp_data  = ram_dout;
    assign ram_en       = ram_en_r;
    assign ram_we       = ram_we_r;
    assign ram_addr     = ram_addr_r;
    assign ram_din      = ram_din_r;
    assign ram_regce    = 1'b1;
    assign ram_rst      = ~rstn;
    assign init_done    = init_done_r;

endmodule

// File: tb/tb_uram_port_arbiter.sv
// Directed self-checking bench for uram_port_arbiter with a behavioural
// UltraRAM model (read data appears 5 edges after request acceptance).
module tb_uram_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 72;

    logic          clk = 1'b0;
    logic          rstn;
    logic          lk_req_valid, lk_req_ready, lk_req_we;
    logic [AW-1:0] lk_req_addr;
    logic [DW-1:0] lk_req_wdata;
    logic          lk_rsp_valid;
    logic [DW-1:0] lk_rsp_data;
    logic          cf_req_valid, cf_req_ready, cf_req_we;
    logic [AW-1:0] cf_req_addr;
    logic [DW-1:0] cf_req_wdata;
    logic          cf_rsp_valid;
    logic [DW-1:0] cf_rsp_data;
    logic          ram_en, ram_we, ram_regce, ram_rst, init_done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [0:4];

    uram_port_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .NBPIPE(3), .STARVE_MAX(7)) dut (
        .clk(clk), .rstn(rstn),
        .lk_req_valid(lk_req_valid), .lk_req_ready(lk_req_ready), .lk_req_we(lk_req_we),
        .lk_req_addr(lk_req_addr), .lk_req_wdata(lk_req_wdata),
        .lk_rsp_valid(lk_rsp_valid), .lk_rsp_data(lk_rsp_data),
        .cf_req_valid(cf_req_valid), .cf_req_ready(cf_req_ready), .cf_req_we(cf_req_we),
        .cf_req_addr(cf_req_addr), .cf_req_wdata(cf_req_wdata),
        .cf_rsp_valid(cf_rsp_valid), .cf_rsp_data(cf_rsp_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_regce(ram_regce), .ram_rst(ram_rst), .ram_dout(ram_dout), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // RAM model: sample port, then 4 more pipeline stages; output reset by ram_rst
    always @(posedge clk) begin
        if (ram_rst) begin
            for (int i = 0; i < 5; i++) rd_pipe[i] <= '0;
        end else begin
            if (ram_en && ram_we) mem[ram_addr] <= ram_din;
            if (ram_en && !ram_we) rd_pipe[0] <= mem[ram_addr];
            for (int i = 1; i < 5; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign ram_dout = rd_pipe[4];

    function automatic logic [DW-1:0] pat(input int i);
        pat = 72'hA5_0000_0000_0000_0000 | DW'(i);
    endfunction

    task automatic idle();
        lk_req_valid = 1'b0; lk_req_we = 1'b0; lk_req_addr = '0; lk_req_wdata = '0;
        cf_req_valid = 1'b0; cf_req_we = 1'b0; cf_req_addr = '0; cf_req_wdata = '0;
    endtask

    task automatic wait_init(input int bound);
        int k;
        k = 0;
        while (!init_done && k < bound) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (init_done !== 1'b1) begin errors++; $display("FAIL init_wait got=%b exp=1 after %0d cycles", init_done, k); end
    endtask

    task automatic test_reset();
        int k;
        rstn = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_din} !== {1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}}) begin
            errors++; $display("FAIL reset_cmd got en=%b we=%b addr=%h din=%h exp all zero", ram_en, ram_we, ram_addr, ram_din);
        end
        checks++;
        if ({lk_rsp_valid, cf_rsp_valid, init_done, ram_rst, ram_regce} !== 5'b00011) begin
            errors++; $display("FAIL reset_flags got %b exp 00011", {lk_rsp_valid, cf_rsp_valid, init_done, ram_rst, ram_regce});
        end
        lk_req_valid = 1'b1; cf_req_valid = 1'b1; lk_req_we = 1'b1; cf_req_we = 1'b1;
        #1;
        checks++;
        if ({lk_req_ready, cf_req_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {lk_req_ready, cf_req_ready}); end
`ifdef URAM_ARB_INIT_EN
        rstn = 1'b1;
        for (k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (init_done) break;
            checks++;
            if ({ram_en, ram_we, ram_addr, ram_din, lk_req_ready, cf_req_ready} !== {1'b1, 1'b1, AW'(k-1), {DW{1'b0}}, 2'b00}) begin
                errors++; $display("FAIL init_sweep edge %0d got en=%b we=%b addr=%h din=%h rdy=%b%b exp addr=%h", k, ram_en, ram_we, ram_addr, ram_din, lk_req_ready, cf_req_ready, AW'(k-1));
            end
        end
        checks++;
        if (k !== (1 << AW) + 1) begin errors++; $display("FAIL init_done_edge got %0d exp %0d", k, (1 << AW) + 1); end
        idle();
`else
        idle();
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (init_done !== 1'b1) begin errors++; $display("FAIL init_done_first_edge got %b exp 1", init_done); end
`endif
        repeat (2) @(negedge clk);
    endtask

    task automatic test_lookup_burst();
        for (int i = 0; i < 10; i++) begin
            lk_req_valid = 1'b1; lk_req_we = 1'b1; lk_req_addr = AW'(i); lk_req_wdata = pat(i);
            #1;
            checks++;
            if (lk_req_ready !== 1'b1) begin errors++; $display("FAIL lk_write_ready addr %0d got %b exp 1", i, lk_req_ready); end
            @(negedge clk);
        end
        idle();
        repeat (7) @(negedge clk);
        for (int n = 0; n <= 16; n++) begin
            checks++;
            if (lk_rsp_valid !== (n >= 6 && n <= 15) || cf_rsp_valid !== 1'b0) begin
                errors++; $display("FAIL burst_valid n=%0d got lk=%b cf=%b exp lk=%b cf=0", n, lk_rsp_valid, cf_rsp_valid, (n >= 6 && n <= 15));
            end
            if (n >= 6 && n <= 15) begin
                checks++;
                if (lk_rsp_data !== pat(n-6)) begin errors++; $display("FAIL burst_data n=%0d got %h exp %h", n, lk_rsp_data, pat(n-6)); end
            end
            if (n < 10) begin
                lk_req_valid = 1'b1; lk_req_we = 1'b0; lk_req_addr = AW'(n);
                #1;
                checks++;
                if (lk_req_ready !== 1'b1) begin errors++; $display("FAIL burst_ready n=%0d got %b exp 1", n, lk_req_ready); end
            end else begin
                idle();
            end
            @(negedge clk);
        end
    endtask

    task automatic test_config_raw();
        for (int n = 0; n <= 10; n++) begin
            checks++;
            if (cf_rsp_valid !== (n == 7) || lk_rsp_valid !== 1'b0) begin
                errors++; $display("FAIL raw_valid n=%0d got cf=%b lk=%b exp cf=%b lk=0", n, cf_rsp_valid, lk_rsp_valid, (n == 7));
            end
            if (n == 7) begin
                checks++;
                if (cf_rsp_data !== 72'hAB) begin errors++; $display("FAIL raw_data got %h exp %h", cf_rsp_data, 72'hAB); end
            end
            idle();
            if (n <= 1) begin
                cf_req_valid = 1'b1; cf_req_we = (n == 0); cf_req_addr = 8'h10; cf_req_wdata = 72'hAB;
                #1;
                checks++;
                if (cf_req_ready !== 1'b1) begin errors++; $display("FAIL raw_ready n=%0d got %b exp 1", n, cf_req_ready); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_starvation();
        logic exp_lk;
        for (int k = 0; k < 24; k++) begin
            lk_req_valid = 1'b1; lk_req_we = 1'b1; lk_req_addr = 8'h20; lk_req_wdata = 72'h1;
            cf_req_valid = 1'b1; cf_req_we = 1'b1; cf_req_addr = 8'h21; cf_req_wdata = 72'h2;
            exp_lk = (k % 8) < 7;
            #1;
            checks++;
            if ({lk_req_ready, cf_req_ready} !== {exp_lk, ~exp_lk}) begin
                errors++; $display("FAIL starve_grant k=%0d got lk=%b cf=%b exp lk=%b cf=%b", k, lk_req_ready, cf_req_ready, exp_lk, ~exp_lk);
            end
            @(negedge clk);
        end
        idle();
        repeat (7) @(negedge clk);
    endtask

    task automatic test_interleaved();
        logic [1:0]    src_q  [0:5];
        logic [DW-1:0] data_q [0:5];
        int            addr_q [0:5];
        logic          exp_lk, exp_cf;
        src_q  = '{2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd0};
        addr_q = '{3, 16, 7, 16, 2, 9};
        data_q = '{pat(3), 72'hAB, pat(7), 72'hAB, pat(2), pat(9)};
        for (int n = 0; n <= 13; n++) begin
            exp_lk = (n >= 6 && n <= 11) ? (src_q[n-6] == 2'd0) : 1'b0;
            exp_cf = (n >= 6 && n <= 11) ? (src_q[n-6] == 2'd1) : 1'b0;
            checks++;
            if ({lk_rsp_valid, cf_rsp_valid} !== {exp_lk, exp_cf}) begin
                errors++; $display("FAIL inter_route n=%0d got lk=%b cf=%b exp lk=%b cf=%b", n, lk_rsp_valid, cf_rsp_valid, exp_lk, exp_cf);
            end
            if (n >= 6 && n <= 11) begin
                checks++;
                if ((exp_lk ? lk_rsp_data : cf_rsp_data) !== data_q[n-6]) begin
                    errors++; $display("FAIL inter_data n=%0d got %h exp %h", n, exp_lk ? lk_rsp_data : cf_rsp_data, data_q[n-6]);
                end
            end
            idle();
            if (n < 6) begin
                if (src_q[n] == 2'd0) begin
                    lk_req_valid = 1'b1; lk_req_addr = AW'(addr_q[n]);
                end else begin
                    cf_req_valid = 1'b1; cf_req_addr = AW'(addr_q[n]);
                end
                #1;
                checks++;
                if ((lk_req_ready | cf_req_ready) !== 1'b1 || (lk_req_ready & cf_req_ready) !== 1'b0) begin
                    errors++; $display("FAIL inter_ready n=%0d got lk=%b cf=%b exp one-hot", n, lk_req_ready, cf_req_ready);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midflight();
        logic [DW-1:0] exp_data;
        for (int n = 0; n < 4; n++) begin
            lk_req_valid = 1'b1; lk_req_we = 1'b0; lk_req_addr = AW'(n);
            @(negedge clk);
        end
        idle();
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_din, lk_rsp_valid, cf_rsp_valid, init_done, lk_req_ready, cf_req_ready} !==
            {1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}, 5'b00000}) begin
            errors++; $display("FAIL midreset_state got en=%b we=%b addr=%h din=%h rsp=%b%b done=%b exp all zero", ram_en, ram_we, ram_addr, ram_din, lk_rsp_valid, cf_rsp_valid, init_done);
        end
        checks++;
        if (ram_dout !== {DW{1'b0}}) begin errors++; $display("FAIL midreset_dout got %h exp 0", ram_dout); end
        rstn = 1'b1;
        for (int n = 5; n <= 14; n++) begin
            checks++;
            if ({lk_rsp_valid, cf_rsp_valid} !== 2'b00) begin
                errors++; $display("FAIL midreset_stale n=%0d got lk=%b cf=%b exp 00", n, lk_rsp_valid, cf_rsp_valid);
            end
            @(negedge clk);
        end
        wait_init(400);
`ifdef URAM_ARB_INIT_EN
        exp_data = '0;
`else
        exp_data = pat(5);
`endif
        for (int n = 0; n <= 8; n++) begin
            if (n == 0) begin
                lk_req_valid = 1'b1; lk_req_we = 1'b0; lk_req_addr = 8'd5;
                #1;
                checks++;
                if (lk_req_ready !== 1'b1) begin errors++; $display("FAIL resume_ready got %b exp 1", lk_req_ready); end
            end else begin
                idle();
            end
            @(negedge clk);
            checks++;
            if (lk_rsp_valid !== (n == 5)) begin errors++; $display("FAIL resume_valid n=%0d got %b exp %b", n, lk_rsp_valid, (n == 5)); end
            if (n == 5) begin
                checks++;
                if (lk_rsp_data !== exp_data) begin errors++; $display("FAIL resume_data got %h exp %h", lk_rsp_data, exp_data); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lookup_burst();
        test_config_raw();
        test_starvation();
        test_interleaved();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uram_port_arbiter.md
# uram_port_arbiter

Two-requester arbiter and sequencer for one port of the classifier's UltraRAM true-dual-port table. It multiplexes a lookup client (high priority) and a configuration client (low priority, starvation-protected) onto a single RAM port and drives that port's enables. It tracks the RAM's fixed read latency and steers each read result back to the requester that issued it, in order. One instance sits in front of each RAM port used by the classifier.

## Interface
- AWIDTH, 12: RAM address width.
- DWIDTH, 72: RAM data width.
- NBPIPE, 3: RAM output pipeline depth; must match the RAM instance.
- STARVE_MAX, 7: maximum consecutive lookup grants while a config request waits; range 1..255.

- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- lk_req_valid / lk_req_ready  in/out  1  lookup request handshake
- lk_req_we  in  1  1 = write, 0 = read
- lk_req_addr  in  AWIDTH  lookup address
- lk_req_wdata  in  DWIDTH  lookup write data
- lk_rsp_valid  out  1  lookup read data valid, single cycle, no backpressure
- lk_rsp_data  out  DWIDTH  lookup read data
- cf_req_valid, cf_req_ready, cf_req_we, cf_req_addr, cf_req_wdata, cf_rsp_valid, cf_rsp_data: config equivalents, same widths
- ram_en, ram_we  out  1  RAM mem_en / we, registered
- ram_addr  out  AWIDTH  registered
- ram_din  out  DWIDTH  registered
- ram_regce  out  1  tied 1
- ram_rst  out  1  active-high RAM output reset = ~rstn (combinational)
- ram_dout  in  DWIDTH  RAM data output
- init_done  out  1  table usable

## Operation
- FSM: INIT -> RUN. In RUN, the block issues at most one RAM command per cycle.
- Handshake: a transfer occurs on the edge where valid && ready. ready may depend combinationally on both valids. No ready is ever asserted outside RUN.
- Grant rule in RUN:
  - only one valid: that requester is granted;
  - both valid: lookup is granted unless starve_cnt == STARVE_MAX, in which case config is granted.
- starve_cnt (8 bits):
  - +1 on each lookup grant while cf_req_valid is high, saturating at STARVE_MAX;
  - cleared on a config grant or whenever cf_req_valid is low.
- Accepted request: on the same edge, ram_en<=1, ram_we<=req_we, ram_addr<=req_addr, ram_din<=req_wdata. With no acceptance, ram_en<=0 and ram_we<=0.
- Read tag pipeline: depth NBPIPE+2, entries {valid, src}. A read acceptance pushes {1, src}; a write or idle cycle pushes {0, x}. The tail drives lk_rsp_valid (src=0) or cf_rsp_valid (src=1).
- rsp_data: both lk_rsp_data and cf_rsp_data = ram_dout, unqualified; meaningful only while the matching rsp_valid is high.
- Ordering: responses are returned in issue order. Lookup and config responses are never asserted in the same cycle.
- Write-then-read to the same address, back-to-back: the read returns the new data.

## Timing
- Reset values (rstn low at an edge):
  - ram_en=0, ram_we=0, ram_addr=0, ram_din=0;
  - all tag entries invalid;
  - lk/cf_rsp_valid=0, both readies=0;
  - starve_cnt=0, init_done=0;
  - state=INIT when the init macro is defined, RUN otherwise.
- Read latency: acceptance at edge E0 gives rsp_valid high for exactly the cycle after edge E0+NBPIPE+2 (5 edges for NBPIPE=3).
- Throughput: one request per cycle, with arbitrary read/write/requester mix.
- Reset mid-operation: in-flight reads are discarded, and no rsp_valid is asserted for them after reset. ram_rst holds ram_dout at 0 during reset.
- init_done: rises on the edge entering RUN and stays high until reset.

## Configuration
- URAM_ARB_INIT_EN defined:
  - INIT sweeps ram_addr from 0 to 2^AWIDTH-1 with ram_en=1, ram_we=1, ram_din=0, one address per cycle;
  - after the last address, RUN is entered on the next edge;
  - init_done rises 2^AWIDTH+1 edges after rstn deasserts;
  - both readies stay low throughout INIT.
- Not defined: RUN is entered directly from reset, init_done=1 on the first edge with rstn high, and the RAM contents are not cleared.

## Test plan
- Lookup reads of addresses 0..9 issued back-to-back with valid held high → ready high every cycle; ten lk_rsp_valid pulses in order, starting 5 edges after the first acceptance (NBPIPE=3).
- Config write addr 0x10=0xAB, then config read 0x10 on the next cycle → cf_rsp_valid with cf_rsp_data=0xAB; lk_rsp_valid stays 0.
- Lookup and config valid held high continuously, STARVE_MAX=7 → 7 lookup grants, 1 config grant, repeating; starve_cnt never exceeds 7.
- Interleaved lookup/config reads → responses routed to the correct port in issue order; lk_rsp_valid and cf_rsp_valid are never high together.
- rstn pulsed low for 1 cycle with 4 reads in flight → no rsp_valid afterwards; outputs at reset values; operation resumes.
- URAM_ARB_INIT_EN defined, AWIDTH=4 → 16 zero-writes to addresses 0..15; init_done rises at edge 17; a subsequent read of addr 5 returns 0.
